serial_fetch_arbiter: RTL
=========================

// Module: serial_fetch_arbiter
// PURPOSE
//  Shares one bit-serial fetch link to the off-chip host between two requesters.
//  - Instruction port: 8b address, 32b word.
//  - Micro-instruction port: 9b address, 44b word.
//  Per transaction: shift the address out MSB first, shift the word in MSB first,
//  then hand the word back to the requester. Sits between the CPU's fetch FSM and
//  the io_in/io_out pins of the chip top.
// PARAMETERS
//  IADDR_W  8   instruction address width (bits shifted out)
//  IDATA_W  32  instruction word width (bits shifted in)
//  MADDR_W  9   micro-instruction address width
//  MDATA_W  44  micro-instruction word width
// PORTS
//  clock     in   1        system clock, all state on rising edge
//  reset     in   1        synchronous, active-high
//  i_req     in   1        instruction fetch request (level)
//  i_addr    in   IADDR_W  instruction address, captured at grant
//  i_gnt     out  1        1-cycle pulse: instruction request accepted
//  i_data    out  IDATA_W  last fetched instruction word
//  i_valid   out  1        1-cycle pulse: i_data updated
//  m_req     in   1        micro fetch request (level)
//  m_addr    in   MADDR_W  micro address, captured at grant
//  m_gnt     out  1        1-cycle pulse: micro request accepted
//  m_data    out  MDATA_W  last fetched micro word
//  m_valid   out  1        1-cycle pulse: m_data updated
//  ser_addr  out  1        serial address bit to host
//  ser_sel   out  1        0 = instruction transaction, 1 = micro transaction
//  ser_data  in   1        serial data bit from host
//  busy      out  1        high when state != IDLE
// BEHAVIOUR
//  - FSM states:
//    - IDLE: on any req, pulse the winner's gnt, latch its addr, set sel -> ADDR.
//    - ADDR: drive ser_addr = addr MSB, shift left each cycle; after AW cycles -> DATA.
//    - DATA: shift ser_data into data reg LSB each edge; after DW cycles -> DONE.
//    - DONE: copy data reg to the port's data output, pulse its valid -> IDLE.
//  - Timing, grant in cycle T:
//    - Address bits on ser_addr in T+1..T+AW.
//    - Data sampled at the ends of T+AW+1..T+AW+DW.
//    - valid in T+AW+DW+1.
//    - Instruction valid is 41 cycles after grant; micro valid is 54 cycles after.
//    - IDLE lasts at least 1 cycle between transactions.
//  - Bit counter is 6b and counts down from width-1 to 0; the state advances when
//    it reaches 0.
//  - Requests:
//    - A requester holds req until it sees gnt.
//    - req still high in IDLE after DONE starts a new transaction.
//    - req changes and addr changes during a transaction are ignored.
//    - A req dropped before grant is never served.
//  - ser_addr = 0 outside ADDR. ser_sel is stable from grant through DONE and holds
//    its value in IDLE.
//  - i_data/m_data hold their value until that port's next DONE. The other port's
//    data is never disturbed.
//  - Reset (any state, including mid-ADDR/DATA):
//    - State goes to IDLE; the transaction is aborted with no valid.
//    - All outputs = 0, data registers = 0, shift registers = 0.
//  - Simultaneous i_req and m_req in IDLE: resolved per CONFIGURATION.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//  - A last-grant flag (reset = micro) is kept.
//  - On a tie, the port not granted last wins; the first tie after reset goes to
//    the instruction port.
//  - A lone request always wins.
//  ARB_ROUND_ROBIN_EN undefined:
//  - Fixed priority: m_req beats i_req. No last-grant flag is implemented.
// TESTING
//  - Instruction fetch:
//    - Stimulus: i_req with i_addr = 8'hA5; host returns 32'hDEADBEEF.
//    - Response: ser_addr = 1,0,1,0,0,1,0,1; ser_sel = 0; i_valid 41 cycles after
//      i_gnt; i_data = DEADBEEF.
//  - Micro fetch:
//    - Stimulus: m_addr = 9'h13F; host returns 44'hF00_1234_5678.
//    - Response: 9 address bits 100111111; m_valid 54 cycles after grant; m_data
//      matches; i_data unchanged.
//  - Tie: i_req and m_req together, twice back-to-back.
//    - Fixed priority: micro, micro.
//    - With ARB_ROUND_ROBIN_EN: instr, then micro.
//  - Mid-transaction reset:
//    - Stimulus: reset asserted in the 10th DATA cycle.
//    - Response: next cycle busy = 0, no valid pulse, data outputs = 0; a new req is
//      granted normally.
//  - Addr change: i_addr changed 8'h01 -> 8'hFF one cycle after grant -> serial
//    address is still 00000001.
//  - Held req: i_req held high -> back-to-back transactions with exactly one IDLE
//    cycle between valid and the next gnt.

Source files
------------

// File: rtl/serial_fetch_arbiter_if.sv
// Handshake and serial-link bundle for serial_fetch_arbiter.
// The arbiter uses the slave modport; requesters and the host use master.
interface serial_fetch_arbiter_if #(
  parameter int unsigned IADDR_W = 8,
  parameter int unsigned IDATA_W = 32,
  parameter int unsigned MADDR_W = 9,
  parameter int unsigned MDATA_W = 44
);
  logic               i_req;
  logic [IADDR_W-1:0] i_addr;
  logic               i_gnt;
  logic [IDATA_W-1:0] i_data;
  logic               i_valid;
  logic               m_req;
  logic [MADDR_W-1:0] m_addr;
  logic               m_gnt;
  logic [MDATA_W-1:0] m_data;
  logic               m_valid;
  logic               ser_addr;
  logic               ser_sel;
  logic               ser_data;
  logic               busy;

  modport slave (
    input  i_req, i_addr, m_req, m_addr, ser_data,
    output i_gnt, i_data, i_valid, m_gnt, m_data, m_valid,
           ser_addr, ser_sel, busy
  );

  modport master (
    output i_req, i_addr, m_req, m_addr, ser_data,
    input  i_gnt, i_data, i_valid, m_gnt, m_data, m_valid,
           ser_addr, ser_sel, busy
  );
endinterface

// File: rtl/serial_fetch_arbiter.sv
// Shares one bit-serial fetch link between an instruction and a micro-instruction requester.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed micro priority.
module serial_fetch_arbiter #(
  parameter int unsigned IADDR_W = 8,
  parameter int unsigned IDATA_W = 32,
  parameter int unsigned MADDR_W = 9,
  parameter int unsigned MDATA_W = 44
) (
  input logic                   clock,
  input logic                   reset,
  serial_fetch_arbiter_if.slave bus
);

  localparam int unsigned ASW = (IADDR_W > MADDR_W) ? IADDR_W : MADDR_W;
  localparam int unsigned DSW = (IDATA_W > MDATA_W) ? IDATA_W : MDATA_W;
  localparam int unsigned CW  = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ASW-1:0]     ash_q, ash_d;
  logic [DSW-1:0]     dsh_q, dsh_d;
  logic               sel_q, sel_d;
  logic [IDATA_W-1:0] idata_q, idata_d;
  logic [MDATA_W-1:0] mdata_q, mdata_d;
  logic               i_win, m_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic               last_m_q, last_m_d;
`endif

  // Grant decision is only meaningful in IDLE and is suppressed while reset is applied.
  always_comb begin
    i_win = 1'b0;
    m_win = 1'b0;
    if (state_q == S_IDLE && !reset) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.i_req && bus.m_req) begin
        i_win = last_m_q;
        m_win = !last_m_q;
      end else begin
        i_win = bus.i_req;
        m_win = bus.m_req;
      end
`else
      m_win = bus.m_req;
      i_win = bus.i_req && !bus.m_req;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ash_d   = ash_q;
    dsh_d   = dsh_q;
    sel_d   = sel_q;
    idata_d = idata_q;
    mdata_d = mdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_m_d = last_m_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_win) begin
          sel_d   = 1'b0;
          ash_d   = ASW'(bus.i_addr) << (ASW - IADDR_W);
          dsh_d   = '0;
          cnt_d   = CW'(IADDR_W - 1);
          state_d = S_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_m_d = 1'b0;
`endif
        end else if (m_win) begin
          sel_d   = 1'b1;
          ash_d   = ASW'(bus.m_addr) << (ASW - MADDR_W);
          dsh_d   = '0;
          cnt_d   = CW'(MADDR_W - 1);
          state_d = S_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_m_d = 1'b1;
`endif
        end
      end
      S_ADDR: begin
        ash_d = ash_q << 1;
        if (cnt_q == '0) begin
          cnt_d   = sel_q ? CW'(MDATA_W - 1) : CW'(IDATA_W - 1);
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        dsh_d = {dsh_q[DSW-2:0], bus.ser_data};
        // The port register takes the completed word on the last sample so it is visible alongside valid.
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (sel_q) begin
            mdata_d = dsh_d[MDATA_W-1:0];
          end else begin
            idata_d = dsh_d[IDATA_W-1:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ash_q   <= '0;
      dsh_q   <= '0;
      sel_q   <= 1'b0;
      idata_q <= '0;
      mdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ash_q   <= ash_d;
      dsh_q   <= dsh_d;
      sel_q   <= sel_d;
      idata_q <= idata_d;
      mdata_q <= mdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_m_q <= last_m_d;
`endif
    end
  end

  assign bus.i_gnt    = i_win;
  assign bus.m_gnt    = m_win;
  assign bus.i_data   = idata_q;
  assign bus.m_data   = mdata_q;
  assign bus.i_valid  = (state_q == S_DONE) && !sel_q;
  assign bus.m_valid  = (state_q == S_DONE) && sel_q;
  assign bus.ser_addr = (state_q == S_ADDR) ? ash_q[ASW-1] : 1'b0;
  assign bus.ser_sel  = sel_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule
